// File: rtl/tetris_nios_pio_pkg.sv
// Shared definitions for the Tetris Nios PIO blocks: register addresses and
// debounce counter sizing.
package tetris_nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tetris_nios_debounce.sv
// Single-bit button conditioner: 2-FF synchronizer followed by a stable-count
// debouncer that accepts a new level after DEBOUNCE_CYCLES matching samples.
module tetris_nios_debounce
  import tetris_nios_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0, sync1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0  <= IDLE_LEVEL;
      sync1  <= IDLE_LEVEL;
      stable <= IDLE_LEVEL;
      cnt    <= '0;
    end else begin
      sync0 <= din;
      sync1 <= sync0;
      // Any sample matching the accepted level restarts the qualification run.
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_nios_buttons_in.sv
// Avalon-MM button input port: debounced levels, press edge capture (W1C),
// interrupt mask and a level IRQ to the Nios.
module tetris_nios_buttons_in
  import tetris_nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] level, level_q, press;
  logic [WIDTH-1:0] irqmask, edgecap, wr_bits, clr_bits;
  logic             wr_en;
  logic             writedata_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    tetris_nios_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[i]),
      .stable (level[i])
    );
  end

  assign wr_en            = chipselect & ~write_n;
  assign wr_bits          = writedata[WIDTH-1:0];
  assign writedata_unused = ^writedata;
  assign clr_bits         = (wr_en && address == ADDR_EDGECAP) ? wr_bits : '0;

  // Press only: previous level idle, current level active.
  assign press = ~(level_q ^ IDLE_VEC) & (level ^ IDLE_VEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= IDLE_VEC;
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      level_q <= level;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= wr_bits;
      // A press landing on the same edge as its clear stays captured.
      edgecap <= (edgecap & ~clr_bits) | press;
    end
  end

  assign irq = |(edgecap & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = level;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tetris_nios_buttons_in.sv
// Scoreboard bench for tetris_nios_buttons_in: reads push expected data/irq,
// a negedge monitor pops and compares while a read is on the bus.
module tb_tetris_nios_buttons_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;
  logic        rd_vld;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  tetris_nios_buttons_in #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always @(negedge clk) begin
    if (rd_vld) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: read seen with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        tests += 2;
        if (readdata !== e.data) begin
          fails++;
          $display("FAIL %s data: got 0x%0h expected 0x%0h", e.name, readdata, e.data);
        end
        if (irq !== e.irq) begin
          fails++;
          $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic ir, input string nm);
    exp_t e;
    e.name = nm;
    e.data = d;
    e.irq  = ir;
    q.push_back(e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_vld     = 1'b1;
    tick();
    rd_vld     = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    rd_vld     = 1'b0;

    // Reset state
    tick(3);
    reset = 1'b0;
    rd(2'd0, 32'hF, 1'b0, "rst_data");
    rd(2'd1, 32'h0, 1'b0, "rst_addr1");
    rd(2'd2, 32'h0, 1'b0, "rst_mask");
    rd(2'd3, 32'h0, 1'b0, "rst_edgecap");

    // Clean press of bit0: DATA changes 6 edges after the pin, EDGECAP one later
    in_port = 4'hE;
    tick(5);
    rd(2'd0, 32'hF, 1'b0, "press_data_e5");
    rd(2'd0, 32'hE, 1'b0, "press_data_e6");
    rd(2'd3, 32'h1, 1'b0, "press_edgecap_e7");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, 1'b0, "press_w1c");
    in_port = 4'hF;
    tick(8);
    rd(2'd0, 32'hF, 1'b0, "release_data");
    rd(2'd3, 32'h0, 1'b0, "release_no_cap");

    // Bounce on bit1 never reaches four consecutive samples
    in_port = 4'hD; tick(3);
    in_port = 4'hF; tick(1);
    in_port = 4'hD; tick(3);
    in_port = 4'hF; tick(8);
    rd(2'd0, 32'hF, 1'b0, "bounce_data");
    rd(2'd3, 32'h0, 1'b0, "bounce_edgecap");

    // IRQ path with mask on bit0, then W1C clears it
    wr(2'd2, 32'hFFFF_FFF1);
    rd(2'd2, 32'h1, 1'b0, "mask_write");
    in_port = 4'hE;
    tick(6);
    rd(2'd0, 32'hE, 1'b0, "irq_data_e6");
    rd(2'd3, 32'h1, 1'b1, "irq_edgecap_e7");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, 1'b0, "irq_w1c");
    in_port = 4'hF;
    tick(10);
    rd(2'd3, 32'h0, 1'b1 & 1'b0, "irq_release_no_cap");
    rd(2'd0, 32'hF, 1'b0, "irq_release_data");

    // W1C of bit2 on the same edge its press arrives: set wins
    in_port = 4'hB;
    tick(6);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, 1'b0, "collide_set_wins");
    wr(2'd2, 32'h5);
    rd(2'd2, 32'h5, 1'b1, "unmask_bit2_irq");
    wr(2'd2, 32'h1);
    rd(2'd3, 32'h4, 1'b0, "mask_drop_keeps_cap");
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0, 1'b0, "collide_clear");
    in_port = 4'hF;
    tick(10);

    // Reset in the middle of a bit3 debounce, pin held low throughout
    in_port = 4'h7;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rd(2'd0, 32'hF, 1'b0, "rstmid_data");
    rd(2'd3, 32'h0, 1'b0, "rstmid_edgecap");
    tick(3);
    rd(2'd0, 32'hF, 1'b0, "rstmid_data_e5");
    rd(2'd0, 32'h7, 1'b0, "rstmid_data_e6");
    rd(2'd3, 32'h8, 1'b0, "rstmid_edgecap_e7");

    tick(2);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
